// File: rtl/barcode_pkg.sv
// Shared types and constants for the barcode line transmitter.
// Holds the FSM state enum, the minimum bit period and the ID width.
package barcode_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int MIN_PERIOD  = 8;
  localparam int BITS_PER_ID = 8;

endpackage

// File: rtl/barcode_tx.sv
// Barcode line transmitter: start pulse, 8 pulse-width coded bits MSB
// first, then a stop gap. Ports: clk, rst_n, send, ID, period in;
// BC (idle high), busy, done, err out. Macro BARCODE_TX_MSB_CHK_EN
// rejects IDs with bit 7 set and pulses err instead of sending.
module barcode_tx #(
  parameter int PER_W      = 22,
  parameter int MIN_PERIOD = barcode_pkg::MIN_PERIOD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             send,
  input  logic [7:0]       ID,
  input  logic [PER_W-1:0] period,
  output logic             BC,
  output logic             busy,
  output logic             done,
  output logic             err
);
  import barcode_pkg::*;

  localparam logic [PER_W-1:0] PMIN = PER_W'(MIN_PERIOD);
  localparam logic [3:0] LAST_BIT = 4'(BITS_PER_ID - 1);

  tx_state_t state, state_nxt;
  logic [PER_W-1:0] pq, pq_nxt;
  logic [PER_W-1:0] cyc, cyc_nxt;
  logic [PER_W-1:0] h, q, low_len;
  logic [7:0] sh, sh_nxt;
  logic [3:0] bits, bits_nxt;
  logic bc_nxt, done_nxt, err_nxt;
  logic req, reject, accept, bit_end;

`ifdef BARCODE_TX_MSB_CHK_EN
  assign reject = ID[7];
`else
  assign reject = 1'b0;
`endif

  // no acceptance in the done cycle: next frame starts after it
  assign req     = (state == IDLE) & send & ~done;
  assign accept  = req & ~reject;
  assign err_nxt = req & reject;
  assign bit_end = (cyc == pq - 1'b1);

  always_comb begin
    state_nxt = state;
    cyc_nxt   = cyc + 1'b1;
    sh_nxt    = sh;
    bits_nxt  = bits;
    pq_nxt    = pq;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        cyc_nxt = '0;
        if (accept) begin
          state_nxt = START;
          sh_nxt    = ID;
          pq_nxt    = (period < PMIN) ? PMIN : period;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt = DATA;
          cyc_nxt   = '0;
          bits_nxt  = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          cyc_nxt  = '0;
          sh_nxt   = {sh[6:0], 1'b0};
          bits_nxt = bits + 1'b1;
          if (bits == LAST_BIT) state_nxt = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_nxt = IDLE;
          cyc_nxt   = '0;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // line level for the upcoming cycle, so BC is a plain flop
  always_comb begin
    h       = pq_nxt >> 1;
    q       = pq_nxt >> 2;
    low_len = sh_nxt[7] ? q : (h + q);
    bc_nxt  = 1'b1;
    unique case (state_nxt)
      START:   bc_nxt = (cyc_nxt >= h);
      DATA:    bc_nxt = (cyc_nxt >= low_len);
      default: bc_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cyc   <= '0;
      pq    <= '0;
      sh    <= '0;
      bits  <= '0;
      BC    <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cyc   <= cyc_nxt;
      pq    <= pq_nxt;
      sh    <= sh_nxt;
      bits  <= bits_nxt;
      BC    <= bc_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= done_nxt;
      err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_barcode_tx.sv
// Self-checking bench for barcode_tx: table of frames with
// hand-computed pulse widths plus reset and reject sequences.
module tb_barcode_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        send = 1'b0;
  logic [7:0]  ID = 8'h00;
  logic [21:0] period = 22'd16;
  logic        BC, busy, done, err;

  int errors = 0;
  int checks = 0;

  barcode_tx dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .send   (send),
    .ID     (ID),
    .period (period),
    .BC     (BC),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] id;
    int per;
    int st_low;
    int st_high;
    int l1;
    int l0;
    int frame;
    int inject;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_frame(input vec_t v);
    int cnt, run, nlow, nhigh, high0, ndone;
    int lows[16];
    logic prev;
    bit fin;
    @(negedge clk);
    ID = v.id;
    period = 22'(v.per);
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    ID = ~v.id;
    period = 22'd3;
    chk("fall_latency", int'(BC), 0);
    chk("busy_rise", int'(busy), 1);
    cnt = 0; run = 1; nlow = 0; nhigh = 0;
    high0 = 0; ndone = 0; prev = 1'b0; fin = 0;
    while (!fin) begin
      if (cnt == v.inject) begin
        send = 1'b1;
        ID = ~v.id;
      end else begin
        send = 1'b0;
      end
      @(negedge clk);
      cnt++;
      if (done) begin
        fin = 1;
      end else if (cnt > v.frame + 20) begin
        chk("frame_timeout", cnt, v.frame);
        fin = 1;
      end else begin
        if (BC != prev) begin
          if (prev == 1'b0) begin
            if (nlow < 16) lows[nlow] = run;
            nlow++;
          end else begin
            if (nhigh == 0) high0 = run;
            nhigh++;
          end
          run = 1;
        end else begin
          run++;
        end
        prev = BC;
      end
    end
    send = 1'b0;
    chk("frame_len", cnt, v.frame);
    chk("low_pulses", nlow, 9);
    chk("start_low", lows[0], v.st_low);
    chk("start_high", high0, v.st_high);
    for (int b = 0; b < 8; b++) begin
      chk($sformatf("bit%0d_low", b), lows[b+1],
          v.id[7-b] ? v.l1 : v.l0);
    end
    chk("busy_at_done", int'(busy), 0);
    chk("bc_at_done", int'(BC), 1);
    chk("err_in_frame", int'(err), 0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) ndone++;
      if (!BC || busy) begin
        chk("idle_after_frame", int'(BC), 1);
        break;
      end
    end
    chk("extra_done", ndone, 0);
  endtask

  initial begin
    vec_t r;
    vecs[0] = '{8'h25, 16, 8, 8, 4, 12, 160, -1};
    vecs[1] = '{8'h25, 5, 4, 4, 2, 6, 80, -1};
    vecs[2] = '{8'h7F, 9, 4, 5, 2, 6, 90, -1};
    vecs[3] = '{8'h3C, 64, 32, 32, 16, 48, 640, -1};
    vecs[4] = '{8'h25, 16, 8, 8, 4, 12, 160, 20};

    #12;
    chk("rst_bc", int'(BC), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_frame(vecs[i]);

    // abort during bit 3 of an all-zero ID (bit 3 low is cycles 64..75)
    @(negedge clk);
    ID = 8'h00;
    period = 22'd16;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    repeat (66) @(negedge clk);
    chk("pre_rst_bc", int'(BC), 0);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_bc", int'(BC), 1);
    chk("async_rst_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    r = '{8'h00, 16, 8, 8, 4, 12, 160, -1};
    run_frame(r);

`ifdef BARCODE_TX_MSB_CHK_EN
    @(negedge clk);
    ID = 8'hA5;
    period = 22'd16;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    chk("err_pulse", int'(err), 1);
    chk("rej_bc", int'(BC), 1);
    chk("rej_busy", int'(busy), 0);
    @(negedge clk);
    chk("err_clear", int'(err), 0);
    begin
      int bad = 0;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (!BC || busy || err) bad++;
      end
      chk("rej_quiet", bad, 0);
    end
`else
    r = '{8'hA5, 12, 6, 6, 3, 9, 120, -1};
    run_frame(r);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/barcode_tx.md
Name: barcode_tx

Overview:
Barcode line transmitter. Serializes an 8-bit ID onto the single-wire BC line using the pulse-width code the barcode receiver decodes.
- Frame: a start pulse sets the reference half-period, then 8 data bits MSB first, then a stop gap.
- Each bit begins with a falling edge. The bit value is the line level P/2 cycles after that edge.
- Used as the stimulus source for the barcode receiver bench and as the emitter in the system-level station model.

Parameters:
- PER_W, 22, width of the period input and the internal cycle counter.
- MIN_PERIOD, 8, smallest bit period (clocks) honoured; smaller requests are clamped to this value.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- send  input  1  one-cycle request to transmit; sampled only in IDLE.
- ID  input  8  byte to transmit; latched when send is accepted.
- period  input  PER_W  bit period P in clocks; latched when send is accepted.
- BC  output  1  serial barcode line; idle high; registered.
- busy  output  1  high while a frame is in progress.
- done  output  1  one-cycle pulse at frame completion.
- err  output  1  one-cycle pulse on a rejected request (only with macro; tied 0 otherwise).

Behaviour:
- Reset values: BC=1, busy=0, done=0, err=0, state=IDLE, counters=0. Reset asserted mid-frame returns BC to 1 immediately and abandons the frame.
- Latched values: on acceptance (IDLE & send) latch shift_reg=ID and Pq=max(period, MIN_PERIOD).
- Derived durations: H=Pq>>1, Q=Pq>>2, L1=Q (low time for a 1), L0=H+Q (low time for a 0). All arithmetic is unsigned PER_W bits; no overflow is possible because Pq < 2^PER_W.
- IDLE: BC=1, busy=0. On send, move to START; BC falls on the cycle after acceptance, and busy rises on that same cycle.
- START: BC low for exactly H cycles, then high for Pq-H cycles, then go to DATA with bitCnt=0.
- DATA: each bit lasts Pq cycles.
  - BC low for L1 cycles if shift_reg[7]=1, or L0 cycles if it is 0; high for the remainder.
  - At the end of the bit: shift left, bitCnt+1.
  - After bit 8 (bitCnt==8), go to STOP.
- STOP: BC high for Pq cycles. In the last cycle, done=1 and the FSM returns to IDLE. busy falls together with the done pulse.
- Frame length: BC falling edge to done is exactly 10*Pq cycles. A new send is accepted on the cycle after done.
- send while busy: ignored, with no queueing. ID and period changes while busy have no effect.
- Single cycle counter cycCnt: cleared at every bit boundary, compared against H/L1/L0/Pq-1. BC is driven from a registered next-value.

Optional Feature:
- Macro BARCODE_TX_MSB_CHK_EN.
- Defined: a send with ID[7]=1 is rejected. err pulses 1 cycle after send, BC stays 1, busy stays 0. This mirrors the receiver's rule that IDs with MSB set are invalid.
- Undefined: every ID is transmitted, and err is constant 0.

Decomposition:
- barcode_pkg holds:
  - the state enum tx_state_t {IDLE, START, DATA, STOP}, 2 bits;
  - localparams MIN_PERIOD and BITS_PER_ID=8.
- No sub-module; a single module with FSM, cycle counter, bit counter and shift register.

Test Plan:
1. P=16, ID=0x25 -> start low 8/high 8; bits 0,0,1,0,0,1,0,1 give low 12,12,4,12,12,4,12,4 cycles; done exactly 160 cycles after BC fall.
2. Loopback into the barcode receiver, P=64, ID=0x3C -> receiver ID=0x3C, ID_vld=1; then clr_ID_vld -> ID_vld=0.
3. send pulsed 20 cycles into a frame with a different ID -> frame unchanged, no second frame, a single done pulse.
4. period=5 -> clamped to 8: start low 4 cycles, bit 1 low 2, bit 0 low 6; done 80 cycles after BC fall.
5. rst_n asserted during bit 3 with BC low -> BC=1, busy=0 asynchronously; the next send after release yields a full correct frame.
6. With BARCODE_TX_MSB_CHK_EN, ID=0xA5 -> err pulse, BC constantly 1, busy 0. Without the macro -> frame transmitted, err=0.
